// File: rtl/button_debounce.sv
// button_debounce
//   Conditioning stage for the front-panel push-buttons. Each raw active-low
//   pin goes through a two-flop synchroniser. An independent per-button FSM
//   then debounces it and produces a stable level plus one-cycle click and
//   release pulses. The click pulses feed the up/down counter directly.
//
//   Optional feature (macro AUTO_REPEAT_EN): while a button stays held, extra
//   clicks are generated after REPEAT_DELAY cycles and then every
//   REPEAT_PERIOD cycles. When the macro is undefined, exactly one click is
//   produced per accepted press.
//
// Ports
//   clk          system clock
//   reset        synchronous reset, active low
//   btn_n        raw button pins, 0 = pressed, asynchronous to clk
//   btn_level    debounced state, 1 = pressed (registered)
//   btn_click    one-cycle pulse per accepted press / repeat (registered)
//   btn_release  one-cycle pulse per accepted release (registered)

module button_debounce_lane #(
  parameter int CNT_W          = 32,
  parameter int DEBOUNCE_DELAY = 500000,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  output logic level,
  output logic click,
  output logic rel
);

  // Elaboration-time sanity checks on the counter configuration.
  if (DEBOUNCE_DELAY < 2 ||
      64'(DEBOUNCE_DELAY) >= (64'(1) << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_debounce_lane: illegal delay configuration");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_DELAY - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, click_d, rel_d;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt, rep_cnt_d;
  logic             rep_run, rep_run_d;  // 0: waiting for the first repeat, 1: periodic
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    click_d = 1'b0;
    rel_d   = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          // Release bounce: back to held without a new click.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    // The repeat counter runs only while staying in HELD. Any other cycle,
    // including entering or leaving HELD, clears it.
    rep_cnt_d = '0;
    rep_run_d = 1'b0;
    if (state == HELD && state_d == HELD) begin
      if (rep_cnt == (rep_run ? RP_LAST : RD_LAST)) begin
        click_d   = 1'b1;
        rep_run_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt + CNT_W'(1);
        rep_run_d = rep_run;
      end
    end
`endif

    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      click <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      click <= click_d;
      rel   <= rel_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt_d;
      rep_run <= rep_run_d;
    end
  end
`endif

endmodule

module button_debounce #(
  parameter int NUM_BTN        = 2,
  parameter int CNT_W          = 32,
  parameter int DEBOUNCE_DELAY = 500000,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_click,
  output logic [NUM_BTN-1:0] btn_release
);

  // Two-flop synchroniser. Both stages reset to the released level.
  logic [NUM_BTN-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    button_debounce_lane #(
      .CNT_W         (CNT_W),
      .DEBOUNCE_DELAY(DEBOUNCE_DELAY),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pressed(~s2[i]),
      .level  (btn_level[i]),
      .click  (btn_click[i]),
      .rel    (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_DELAY=8, REPEAT_DELAY=40
// and REPEAT_PERIOD=10. Row i drives inputs before posedge i. The outputs
// registered at that posedge are checked on the following negedge. A button
// that is low from row k produces a click at row k+9.
module tb_button_debounce;

  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] btn_level, btn_click, btn_release;

  int n_chk  = 0;
  int n_fail = 0;

  button_debounce #(
    .NUM_BTN(NB), .CNT_W(8), .DEBOUNCE_DELAY(8),
    .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .btn_level(btn_level), .btn_click(btn_click), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] bn;
    logic          rst;
    logic [NB-1:0] lvl;
    logic [NB-1:0] clk_p;
    logic [NB-1:0] rel_p;
  } vec_t;

  vec_t tbl [38];

  // Called at a negedge: drive the row, then wait until the next negedge.
  task automatic step(input logic [NB-1:0] bn, input logic r);
    btn_n = bn;
    reset = r;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int row, input logic [NB-1:0] got,
                     input logic [NB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, got, exp);
    end
  endtask

  task automatic chk3(input string name, input int row, input logic [NB-1:0] lvl,
                      input logic [NB-1:0] ck, input logic [NB-1:0] rl);
    chk({name, ".level"},   row, btn_level,   lvl);
    chk({name, ".click"},   row, btn_click,   ck);
    chk({name, ".release"}, row, btn_release, rl);
  endtask

  initial begin
    // Table: rows 0-2 in reset, clean press of btn0 from row 6 (click at 15),
    // release from row 25 (release pulse at 34).
    for (int r = 0; r < 38; r++) begin
      tbl[r].rst   = (r >= 3);
      tbl[r].bn    = (r >= 6 && r < 25) ? 2'b10 : 2'b11;
      tbl[r].lvl   = (r >= 15 && r < 34) ? 2'b01 : 2'b00;
      tbl[r].clk_p = (r == 15) ? 2'b01 : 2'b00;
      tbl[r].rel_p = (r == 34) ? 2'b01 : 2'b00;
    end

    btn_n = '1;
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 38; r++) begin
      step(tbl[r].bn, tbl[r].rst);
      chk3("table", r, tbl[r].lvl, tbl[r].clk_p, tbl[r].rel_p);
    end

    // Bouncy press: low 5, high 1, low steady. Click 9 rows after the final fall.
    for (int i = 0; i < 22; i++) begin
      step((i < 5 || i >= 6) ? 2'b10 : 2'b11, 1'b1);
      chk3("bounce", i, (i >= 15) ? 2'b01 : 2'b00, (i == 15) ? 2'b01 : 2'b00, 2'b00);
    end
    // Release for 20 rows.
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 1'b1);
      chk3("bounce_rel", i, (i < 9) ? 2'b01 : 2'b00, 2'b00, (i == 9) ? 2'b01 : 2'b00);
    end

    // Simultaneous press; btn1 released at row 30.
    for (int i = 0; i < 45; i++) begin
      step((i < 30) ? 2'b00 : 2'b10, 1'b1);
      chk3("simul", i,
           (i < 9) ? 2'b00 : (i < 39) ? 2'b11 : 2'b01,
           (i == 9) ? 2'b11 : 2'b00,
           (i == 39) ? 2'b10 : 2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1'b1);
      chk3("simul_rel", i, (i < 9) ? 2'b01 : 2'b00, 2'b00, (i == 9) ? 2'b01 : 2'b00);
    end

    // Release glitch: held btn0 goes high for 3 rows then low again.
    for (int i = 0; i < 21; i++) begin
      step((i >= 12 && i < 15) ? 2'b11 : 2'b10, 1'b1);
      chk3("rel_glitch", i, (i >= 9) ? 2'b01 : 2'b00, (i == 9) ? 2'b01 : 2'b00, 2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1'b1);
      chk3("rel_glitch_rel", i, (i < 9) ? 2'b01 : 2'b00, 2'b00, (i == 9) ? 2'b01 : 2'b00);
    end

    // Reset mid-debounce: asserted on rows 6-7, button stays low.
    // The first posedge with reset high is row 8, so the click comes at row 17.
    for (int i = 0; i < 21; i++) begin
      step(2'b10, (i == 6 || i == 7) ? 1'b0 : 1'b1);
      chk3("rst_mid", i, (i >= 17) ? 2'b01 : 2'b00, (i == 17) ? 2'b01 : 2'b00, 2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1'b1);
      chk3("rst_mid_rel", i, (i < 9) ? 2'b01 : 2'b00, 2'b00, (i == 9) ? 2'b01 : 2'b00);
    end

    // Long hold: 100 rows low.
    begin
      int clicks;
      clicks = 0;
      for (int i = 0; i < 100; i++) begin
        logic exp_ck;
`ifdef AUTO_REPEAT_EN
        exp_ck = (i == 9) || (i >= 49 && (i - 49) % 10 == 0);
`else
        exp_ck = (i == 9);
`endif
        step(2'b10, 1'b1);
        if (btn_click[0]) clicks++;
        chk3("hold", i, (i >= 9) ? 2'b01 : 2'b00, {1'b0, exp_ck}, 2'b00);
      end
`ifdef AUTO_REPEAT_EN
      chk("hold.count", 0, clicks[NB-1:0], 2'd3);  // 7 clicks, low 2 bits = 3
`else
      chk("hold.count", 0, clicks[NB-1:0], 2'd1);
`endif
    end
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1'b1);
      chk3("hold_rel", i, (i < 9) ? 2'b01 : 2'b00, 2'b00, (i == 9) ? 2'b01 : 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the front-panel push-buttons.
- Synchronises NUM_BTN raw active-low button inputs to clk and debounces each one independently with a per-button state machine.
- Emits a stable pressed level plus single-cycle click and release pulses.
- The click pulses drive the up/down counter and seven-segment display stage directly.

Parameters:
- NUM_BTN, 2: number of independent buttons.
- CNT_W, 32: width of each debounce/repeat counter.
- DEBOUNCE_DELAY, 500000: consecutive stable cycles required to accept a press or a release (5 ms at 100 MHz). Legal range 2 .. 2^CNT_W-1.
- REPEAT_DELAY, 50000000: cycles held before the first auto-repeat click. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat clicks. Used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: synchronous, active-low reset.
- btn_n, input, NUM_BTN: raw button pins; 0 = pressed; asynchronous to clk.
- btn_level, output, NUM_BTN: debounced state; 1 = pressed.
- btn_click, output, NUM_BTN: one-cycle pulse per accepted press (and per repeat when enabled).
- btn_release, output, NUM_BTN: one-cycle pulse per accepted release.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: sampled only on the posedge of clk while reset==0.
- Reset values:
  - sync flops = 1 (released).
  - All FSMs in IDLE; all counters 0.
  - btn_level = 0, btn_click = 0, btn_release = 0, all registered.
  - Reset asserted mid-debounce or mid-hold aborts the operation. No click or release pulse is emitted for an aborted press.
- Synchroniser: two flops per bit, s1 <= btn_n and s2 <= s1. pressed_i = !s2[i].
- Per-button FSM (buttons fully independent; any mix may be active in the same cycle):
  - IDLE: btn_level=0. If pressed_i: go to PRESS_WAIT, cnt=1.
  - PRESS_WAIT: btn_level=0.
    - If !pressed_i: go to IDLE, cnt=0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_DELAY-1: go to HELD, cnt=0, btn_click=1 for exactly one cycle.
    - Else cnt++.
  - HELD: btn_level=1. If !pressed_i: go to RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: btn_level=1.
    - If pressed_i: go back to HELD, cnt=0 (no new click).
    - Else if cnt==DEBOUNCE_DELAY-1: go to IDLE, btn_release=1 for one cycle.
    - Else cnt++.
- Outputs: btn_level, btn_click and btn_release are registered. btn_click and btn_release rise in the same cycle that btn_level changes.
- Latency: btn_n held low continuously from posedge k gives btn_click high during cycle k+DEBOUNCE_DELAY+2. Release latency is identical.
- Glitch rejection: a glitch shorter than DEBOUNCE_DELAY-1 synced cycles in either wait state produces no pulse and leaves btn_level unchanged.
- Pulse pairing: click and release for the same button are never asserted in the same cycle. Every release pulse is preceded by exactly one press click.
- Counters never wrap: the compare terminates counting before overflow.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: each button has a repeat counter that runs only in HELD.
  - First extra btn_click after REPEAT_DELAY cycles in HELD, then one every REPEAT_PERIOD cycles.
  - The counter clears on entering HELD, on leaving HELD, and on reset.
  - Moving HELD -> RELEASE_WAIT -> HELD (release bounce) restarts the REPEAT_DELAY count.
- Undefined: no repeat counter logic. Exactly one btn_click per accepted press.

Test Plan (DEBOUNCE_DELAY=8, REPEAT_DELAY=40, REPEAT_PERIOD=10):
- Clean press: btn_n[0] 1->0 at posedge 10, held -> btn_click[0] high only in cycle 20; btn_level[0]=1 from cycle 20.
- Bouncy press: btn_n[0] low 5 cycles, high 1, then low steady -> no click during the bounce; single click 10 cycles after the final falling edge.
- Release: the steady press from the previous case released for 20 cycles -> btn_release[0] one-cycle pulse 10 cycles after the rising edge; btn_level[0]=0 at the same cycle; no click.
- Simultaneous: btn_n[1:0] both fall at cycle 0 -> btn_click=2'b11 in cycle 10; btn_n[1] released at cycle 30 -> only btn_release[1] at cycle 40.
- Reset mid-operation: reset=0 at cycle 6 of a press debounce, released at cycle 8 with the button still low -> no click from the aborted press. The FSM restarts from IDLE, and a click occurs 10 cycles after the first post-reset posedge with reset==1.
- AUTO_REPEAT_EN: hold btn_n[0] low for 100 cycles -> clicks at cycles 10, 50, 60, 70, 80, 90, 100. Without the macro, only cycle 10.
